// File: rtl/pps_phase_detector_pkg.sv
// Shared constants and the signed saturation helper used by the PPS phase detector.
package pps_phase_detector_pkg;

  localparam int NOMINAL_200M = 200_000_000;
  localparam int ERR_W_DEF    = 16;

  // Clamp a signed value into the range representable by a w-bit two's complement word.
  function automatic logic signed [63:0] sat_to_width(input logic signed [63:0] v,
                                                      input int unsigned       w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 32'd1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) begin
      return hi;
    end else if (v < lo) begin
      return lo;
    end else begin
      return v;
    end
  endfunction

endpackage

// File: rtl/pps_phase_detector_ref_edge_locator.sv
// Priority encoder over the ref_clk sample window: newest rising edge (lowest index) wins.
module ref_edge_locator #(
  parameter int SHIFT_LEN = 20,
  parameter int PH_W      = $clog2(SHIFT_LEN)
) (
  input  logic [SHIFT_LEN-1:0] shft_i,
  output logic                 found_o,
  output logic [PH_W-1:0]      index_o
);

  // Scan from oldest to newest so the lowest matching index is the one left standing.
  always_comb begin
    found_o = 1'b0;
    index_o = '1;
    for (int i = SHIFT_LEN - 2; i >= 0; i--) begin
      if (shft_i[i] && !shft_i[i+1]) begin
        found_o = 1'b1;
        index_o = PH_W'(i);
      end else begin
        found_o = found_o;
        index_o = index_o;
      end
    end
  end

endmodule

// File: rtl/pps_phase_detector.sv
// PPS period / ref_clk phase measurement feeding the DPLL loop filter; flags loss of PPS.
module pps_phase_detector
  import pps_phase_detector_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int ERR_W       = ERR_W_DEF,
  parameter int NOMINAL     = NOMINAL_200M,
  parameter int LOST_MARGIN = 1000,
  parameter int SHIFT_LEN   = 20,
  parameter int PH_W        = $clog2(SHIFT_LEN)
) (
  input  logic             clk_200,
  input  logic             reset,
  input  logic             enable,
  input  logic             pps_in,
  input  logic             ref_clk_in,
  output logic             meas_valid,
  output logic [CNT_W-1:0] period_count,
  output logic [ERR_W-1:0] period_err,
  output logic [PH_W-1:0]  ref_phase,
  output logic             ref_phase_valid,
  output logic             pps_lost,
  output logic [15:0]      meas_count
);

  localparam logic [CNT_W-1:0]        LOST_AT = CNT_W'(NOMINAL + LOST_MARGIN);
  localparam logic signed [CNT_W:0]   NOM_V   = (CNT_W + 1)'(NOMINAL);

  logic                 pps_s1_q, pps_s2_q, pps_dly_q, ref_s1_q;
  logic [SHIFT_LEN-1:0] shft_q;
  logic [CNT_W-1:0]     cnt_q, cnt_d, cnt_inc_s;
  logic                 armed_q, armed_d, lost_q, lost_d, mv_q, mv_d, pv_q, pv_d;
  logic [CNT_W-1:0]     pc_q, pc_d;
  logic [ERR_W-1:0]     err_q, err_d, err_sat_s;
  logic [PH_W-1:0]      ph_q, ph_d, loc_idx_s;
  logic [15:0]          mc_q, mc_d;
  logic                 loc_found_s, pps_edge_s;
  logic signed [CNT_W:0] diff_s;

  // Synchronisers; shft_q[0] plays the role of the second ref stage so both paths share latency.
  always_ff @(posedge clk_200 or posedge reset) begin
    if (reset) begin
      pps_s1_q  <= 1'b0;
      pps_s2_q  <= 1'b0;
      pps_dly_q <= 1'b0;
      ref_s1_q  <= 1'b0;
      shft_q    <= '0;
    end else begin
      pps_s1_q  <= pps_in;
      pps_s2_q  <= pps_s1_q;
      pps_dly_q <= pps_s2_q;
      ref_s1_q  <= ref_clk_in;
      shft_q    <= {shft_q[SHIFT_LEN-2:0], ref_s1_q};
    end
  end

  assign pps_edge_s = pps_s2_q & ~pps_dly_q;
  assign cnt_inc_s  = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
  assign diff_s     = $signed({1'b0, cnt_inc_s}) - NOM_V;
  assign err_sat_s  = ERR_W'(sat_to_width(64'(diff_s), ERR_W));

  ref_edge_locator #(
    .SHIFT_LEN (SHIFT_LEN),
    .PH_W      (PH_W)
  ) u_locator (
    .shft_i  (shft_q),
    .found_o (loc_found_s),
    .index_o (loc_idx_s)
  );

  // Counter, arm/lost flags and measurement capture.
  always_comb begin
    cnt_d   = cnt_q;
    armed_d = armed_q;
    lost_d  = lost_q;
    mv_d    = 1'b0;
    pc_d    = pc_q;
    err_d   = err_q;
    ph_d    = ph_q;
    pv_d    = pv_q;
    mc_d    = mc_q;
    if (!enable) begin
      cnt_d   = '0;
      armed_d = 1'b0;
      lost_d  = 1'b0;
    end else if (pps_edge_s) begin
      cnt_d   = '0;
      armed_d = 1'b1;
      lost_d  = 1'b0;
      if (armed_q && !lost_q) begin
        mv_d  = 1'b1;
        pc_d  = cnt_inc_s;
        err_d = err_sat_s;
        ph_d  = loc_idx_s;
        pv_d  = loc_found_s;
        mc_d  = mc_q + 16'd1;
      end else begin
        mv_d  = 1'b0;
      end
    end else begin
      cnt_d = cnt_inc_s;
      if (cnt_inc_s == LOST_AT) begin
        lost_d = 1'b1;
      end else begin
        lost_d = lost_q;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk_200 or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      armed_q <= 1'b0;
      lost_q  <= 1'b0;
      mv_q    <= 1'b0;
      pc_q    <= '0;
      err_q   <= '0;
      ph_q    <= '1;
      pv_q    <= 1'b0;
      mc_q    <= 16'd0;
    end else begin
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
      lost_q  <= lost_d;
      mv_q    <= mv_d;
      pc_q    <= pc_d;
      err_q   <= err_d;
      ph_q    <= ph_d;
      pv_q    <= pv_d;
      mc_q    <= mc_d;
    end
  end

  assign meas_valid      = mv_q;
  assign period_count    = pc_q;
  assign period_err      = err_q;
  assign ref_phase       = ph_q;
  assign ref_phase_valid = pv_q;
  assign pps_lost        = lost_q;
  assign meas_count      = mc_q;

endmodule

// File: tb/tb_pps_phase_detector.sv
// Bench: two detector instances (ERR_W 16 / margin 50 and ERR_W 8 / margin 300) on shared stimulus.
module tb_pps_phase_detector;

  localparam int NOM = 1000;
  localparam int SL  = 20;

  logic clk_200 = 1'b0, reset = 1'b1, enable = 1'b0, pps_in = 1'b0, ref_clk_in = 1'b0;
  logic        mv_a, pv_a, lost_a, mv_b, pv_b, lost_b;
  logic [31:0] pc_a, pc_b;
  logic [15:0] err_a, mc_a, mc_b;
  logic [7:0]  err_b;
  logic [4:0]  ph_a, ph_b;

  pps_phase_detector #(.CNT_W(32), .ERR_W(16), .NOMINAL(NOM), .LOST_MARGIN(50), .SHIFT_LEN(SL)) dut_a (
    .clk_200(clk_200), .reset(reset), .enable(enable), .pps_in(pps_in), .ref_clk_in(ref_clk_in),
    .meas_valid(mv_a), .period_count(pc_a), .period_err(err_a), .ref_phase(ph_a),
    .ref_phase_valid(pv_a), .pps_lost(lost_a), .meas_count(mc_a));

  pps_phase_detector #(.CNT_W(32), .ERR_W(8), .NOMINAL(NOM), .LOST_MARGIN(300), .SHIFT_LEN(SL)) dut_b (
    .clk_200(clk_200), .reset(reset), .enable(enable), .pps_in(pps_in), .ref_clk_in(ref_clk_in),
    .meas_valid(mv_b), .period_count(pc_b), .period_err(err_b), .ref_phase(ph_b),
    .ref_phase_valid(pv_b), .pps_lost(lost_b), .meas_count(mc_b));

  always #5 clk_200 = ~clk_200;

  int nvec = 0, nfail = 0;
  bit chk_en = 1'b0;

  // Reference model: input history per sampled clock, measurements from edge timestamps.
  bit pps_h [0:131071];
  bit ref_h [0:131071];
  int k = 0;
  int m_zero [2], m_pc [2], m_err [2], m_ph [2], m_mc [2];
  bit m_armed [2], m_lost [2], m_mv [2], m_pv [2];
  bit m_rise;
  int thr [2] = '{1050, 1300};
  int ew  [2] = '{16, 8};

  function automatic bit hp(input int i);
    return (i >= 1) ? pps_h[i] : 1'b0;
  endfunction

  function automatic bit hr(input int i);
    return (i >= 1) ? ref_h[i] : 1'b0;
  endfunction

  function automatic int clampw(input int v, input int w);
    int hi, lo;
    hi = (1 <<< (w - 1)) - 1;
    lo = -(1 <<< (w - 1));
    return (v > hi) ? hi : ((v < lo) ? lo : v);
  endfunction

  task automatic model_reset();
    k = 0;
    for (int u = 0; u < 2; u++) begin
      m_zero[u] = 0; m_armed[u] = 0; m_lost[u] = 0; m_mv[u] = 0;
      m_pc[u] = 0; m_err[u] = 0; m_ph[u] = 31; m_pv[u] = 0; m_mc[u] = 0;
    end
  endtask

  always @(posedge clk_200 or posedge reset) begin
    if (reset) begin
      model_reset();
    end else begin
      k = k + 1;
      pps_h[k] = pps_in;
      ref_h[k] = ref_clk_in;
      m_rise = hp(k - 2) && !hp(k - 3);
      for (int u = 0; u < 2; u++) begin
        m_mv[u] = 0;
        if (!enable) begin
          m_armed[u] = 0; m_lost[u] = 0; m_zero[u] = k;
        end else if (m_rise) begin
          if (m_armed[u] && !m_lost[u]) begin
            m_pc[u]  = k - m_zero[u];
            m_err[u] = clampw(m_pc[u] - NOM, ew[u]);
            m_ph[u]  = 31; m_pv[u] = 0;
            for (int i = 0; i <= SL - 2; i++) begin
              if (!m_pv[u] && hr(k - 2 - i) && !hr(k - 3 - i)) begin
                m_ph[u] = i; m_pv[u] = 1;
              end
            end
            m_mv[u] = 1;
            m_mc[u] = (m_mc[u] + 1) % 65536;
          end
          m_armed[u] = 1; m_lost[u] = 0; m_zero[u] = k;
        end else if (k - m_zero[u] == thr[u]) begin
          m_lost[u] = 1;
        end
      end
    end
  end

  task automatic cmp_model(input int u, input logic mv, input logic [31:0] pc, input int err,
                           input logic [4:0] ph, input logic pv, input logic lost, input logic [15:0] mc);
    nvec++;
    if (mv !== m_mv[u] || pc !== 32'(m_pc[u]) || err != m_err[u] || ph !== 5'(m_ph[u]) ||
        pv !== m_pv[u] || lost !== m_lost[u] || mc !== 16'(m_mc[u])) begin
      nfail++;
      $display("FAIL model_inst%0d t=%0t got mv=%b pc=%0d err=%0d ph=%0d pv=%b lost=%b mc=%0d, expected mv=%b pc=%0d err=%0d ph=%0d pv=%b lost=%b mc=%0d",
               u, $time, mv, pc, err, ph, pv, lost, mc,
               m_mv[u], m_pc[u], m_err[u], m_ph[u], m_pv[u], m_lost[u], m_mc[u]);
    end
  endtask

  always @(negedge clk_200) begin
    if (chk_en) begin
      cmp_model(0, mv_a, pc_a, $signed(err_a), ph_a, pv_a, lost_a, mc_a);
      cmp_model(1, mv_b, pc_b, $signed(err_b), ph_b, pv_b, lost_b, mc_b);
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    nvec++;
    if (got != exp) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // mode <0: ref stuck low; 0..7: 8-cycle clock rising mode samples before the PPS; else random bits.
  function automatic logic ref_val(input int j, input int gap, input int mode);
    int m;
    if (mode < 0) return 1'b0;
    if (mode < 8) begin
      m = (((j - (gap - mode)) % 8) + 8) % 8;
      return (m < 4);
    end
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic drive_cycle(input int j, input int gap, input int mode, input bit p);
    @(negedge clk_200);
    pps_in     = p;
    ref_clk_in = ref_val(j, gap, mode);
  endtask

  // PPS rise sampled at j == gap; then three more samples so the strobe is visible on return.
  task automatic pulse(input int gap, input int mode, input int first_j);
    for (int j = first_j; j <= gap; j++) drive_cycle(j, gap, mode, j == gap);
    for (int j = gap + 1; j <= gap + 3; j++) drive_cycle(j, gap, mode, 1'b0);
  endtask

  typedef struct {
    int gap; int mode;
    bit a_mv; int a_pc; int a_err;
    bit b_mv; int b_pc; int b_err;
    int ph; bit pv;
  } row_t;
  row_t rows [13];

  initial begin
    int got;
    row_t r;
    rows[0]  = '{1000, 4, 0, 0,    0,    0, 0,    0,    0,  0};
    rows[1]  = '{1000, 4, 1, 1000, 0,    1, 1000, 0,    4,  1};
    rows[2]  = '{1000,-1, 1, 1000, 0,    1, 1000, 0,    31, 0};
    rows[3]  = '{1003, 0, 1, 1003, 3,    1, 1003, 3,    0,  1};
    rows[4]  = '{995,  7, 1, 995, -5,    1, 995, -5,    7,  1};
    rows[5]  = '{1050, 3, 1, 1050, 50,   1, 1050, 50,   3,  1};
    rows[6]  = '{1051, 2, 0, 0,    0,    1, 1051, 51,   2,  1};
    rows[7]  = '{1200, 5, 0, 0,    0,    1, 1200, 127,  5,  1};
    rows[8]  = '{800,  1, 1, 800, -200,  1, 800, -128,  1,  1};
    rows[9]  = '{1128, 6, 0, 0,    0,    1, 1128, 127,  6,  1};
    rows[10] = '{871,  3, 1, 871, -129,  1, 871, -128,  3,  1};
    rows[11] = '{1127, 0, 0, 0,    0,    1, 1127, 127,  0,  1};
    rows[12] = '{1000, 6, 1, 1000, 0,    1, 1000, 0,    6,  1};

    repeat (3) @(negedge clk_200);
    chk("rst_mv_a", mv_a, 0); chk("rst_pc_a", pc_a, 0); chk("rst_err_a", err_a, 0);
    chk("rst_ph_a", ph_a, 31); chk("rst_pv_a", pv_a, 0); chk("rst_lost_a", lost_a, 0);
    chk("rst_mc_a", mc_a, 0); chk("rst_ph_b", ph_b, 31);
    chk_en = 1'b1;
    reset  = 1'b0;
    enable = 1'b1;

    for (int i = 0; i < 13; i++) begin
      r = rows[i];
      pulse(r.gap, r.mode, (i == 0) ? 1 : 4);
      nvec++;
      if (mv_a !== r.a_mv || (r.a_mv && (pc_a != r.a_pc || $signed(err_a) != r.a_err ||
          ph_a != r.ph || pv_a != r.pv))) begin
        nfail++;
        $display("FAIL row%0d_a: got mv=%b pc=%0d err=%0d ph=%0d pv=%b, expected mv=%b pc=%0d err=%0d ph=%0d pv=%b",
                 i, mv_a, pc_a, $signed(err_a), ph_a, pv_a, r.a_mv, r.a_pc, r.a_err, r.ph, r.pv);
      end
      nvec++;
      if (mv_b !== r.b_mv || (r.b_mv && (pc_b != r.b_pc || $signed(err_b) != r.b_err ||
          ph_b != r.ph || pv_b != r.pv))) begin
        nfail++;
        $display("FAIL row%0d_b: got mv=%b pc=%0d err=%0d ph=%0d pv=%b, expected mv=%b pc=%0d err=%0d ph=%0d pv=%b",
                 i, mv_b, pc_b, $signed(err_b), ph_b, pv_b, r.b_mv, r.b_pc, r.b_err, r.ph, r.pv);
      end
    end

    // Loss of PPS: flag rises exactly 1050 cycles after the last measurement strobe.
    got = 0;
    for (int n = 1; n <= 1100; n++) begin
      drive_cycle(n, 2000, -1, 1'b0);
      if (lost_a === 1'b1 && got == 0) got = n;
    end
    chk("lost_delay", got, 1050);
    pulse(900, -1, 1);
    chk("relock_no_strobe", mv_a, 0);
    chk("relock_lost_clear", lost_a, 0);
    pulse(1000, 4, 4);
    chk("relock_measure_mv", mv_a, 1);
    chk("relock_measure_pc", pc_a, 1000);

    // Asynchronous reset 400 cycles into a period.
    for (int n = 4; n < 404; n++) drive_cycle(n, 1000, 4, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk("arst_mv_a", mv_a, 0); chk("arst_pc_a", pc_a, 0); chk("arst_err_a", err_a, 0);
    chk("arst_ph_a", ph_a, 31); chk("arst_pv_a", pv_a, 0); chk("arst_mc_a", mc_a, 0);
    chk("arst_pc_b", pc_b, 0);
    repeat (3) drive_cycle(0, 1000, -1, 1'b0);
    reset = 1'b0;
    pulse(1000, 4, 1);
    chk("arst_first_arms", mv_a, 0);
    pulse(1000, 4, 4);
    chk("arst_second_mv", mv_a, 1);
    chk("arst_second_mc", mc_a, 1);

    // Enable low: PPS ignored; first PPS after re-enable only arms.
    enable = 1'b0;
    pulse(300, -1, 4);
    chk("dis_no_strobe", mv_a, 0);
    enable = 1'b1;
    pulse(1000, -1, 4);
    chk("en_first_arms", mv_a, 0);
    pulse(1000, 3, 4);
    chk("en_measure_pc", pc_a, 1000);
    chk("en_measure_ph", ph_a, 3);

    // Randomised periods and ref patterns against the model.
    for (int i = 0; i < 25; i++) begin
      int rm;
      rm = $urandom_range(0, 9);
      pulse($urandom_range(960, 1060), (rm == 8) ? -1 : ((rm == 9) ? 100 : rm), 4);
    end

    @(negedge clk_200);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
